mac_rx_parser: RTL and testbench
================================

# mac_rx_parser

Parametrised successor receive MAC for the 8-bit GMII-style PHY interface in the Ethernet path. It parses preamble/SFD/header, filters on destination address, strips the FCS through a delay line, and streams payload bytes to the upper layer with sof/eof/err framing. It also keeps saturating good/drop frame counters.

## Interface
Parameters:
- `MIN_FRAME`, 64: minimum legal frame bytes, counted from dest MAC through FCS inclusive.
- `MAX_FRAME`, 1518: maximum legal frame bytes, same counting.
- `CNT_W`, 16: width of the statistics counters.

Ports:
- `in_rxc`  in  1: receive clock; the only clock.
- `in_rst_n`  in  1: asynchronous, active-low reset.
- `in_rxdv`  in  1: receive data valid.
- `in_rxd`  in  8: receive data.
- `in_rxer`  in  1: receive error.
- `in_station_mac`  in  48: own MAC; first wire byte in bits [47:40].
- `in_promisc`  in  1: accept any destination.
- `out_valid`  out  1: payload byte valid.
- `out_data`  out  8: payload byte.
- `out_sof`  out  1: first payload byte of a frame.
- `out_eof`  out  1: last payload byte.
- `out_err`  out  1: frame bad; meaningful only with `out_eof`.
- `out_dest_mac`  out  48: parsed destination MAC.
- `out_src_mac`  out  48: parsed source MAC.
- `out_ether_type`  out  16: parsed EtherType/length.
- `out_frame_cnt`  out  CNT_W: good frames; saturates at all-ones.
- `out_drop_cnt`  out  CNT_W: dropped/errored frames; saturates at all-ones.

## Operation
- States: IDLE, PREAMBLE, HEADER, PAYLOAD, DROP.
- IDLE: `in_rxdv`=1 with byte 0x55 -> PREAMBLE. Any other byte -> DROP.
- PREAMBLE: 0x55 stays in PREAMBLE (any count). 0xD5 -> HEADER with byte count cleared. Any other byte -> DROP.
- HEADER: 14 bytes, big-endian into dest/src/type.
  - After dest byte 6: accept if `in_promisc`, dest == `in_station_mac`, or dest == FF:FF:FF:FF:FF:FF.
  - Otherwise -> DROP.
  - After byte 14 -> PAYLOAD.
- PAYLOAD: each byte shifts into a 4-byte FCS delay line. The byte leaving the line loads the pending register P. A previously valid P is emitted with `out_valid`=1. `out_sof`=1 on the first emission of the frame.
- End of frame is the first cycle with `in_rxdv`=0 in PAYLOAD:
  - If P is valid, emit P with `out_eof`=1 and `out_err` set per the error rule.
  - `out_frame_cnt` increments if err=0; otherwise `out_drop_cnt` increments.
  - If P was never valid (fewer than 5 post-header bytes), emit nothing and increment `out_drop_cnt`.
  - Return to IDLE.
- Error rule: `out_err` = `in_rxer` seen any cycle since SFD, OR frame bytes < `MIN_FRAME`, OR (FCS check enabled and FCS bad).
- Oversize: on frame byte count reaching `MAX_FRAME`+1 in PAYLOAD:
  - Emit P with eof=1, err=1 and increment `out_drop_cnt`.
  - Go to DROP.
- DROP: no output; stays until `in_rxdv`=0, then IDLE. Entry from IDLE, PREAMBLE or HEADER increments `out_drop_cnt` once.
- `in_rxdv` falling in PREAMBLE or HEADER: go to IDLE, increment `out_drop_cnt`.
- Byte counter: 11 bits, saturating. Counters saturate and never wrap.

## Timing
- Reset (async assert, sync release): state IDLE; all outputs 0; delay line and P cleared. Reset asserted mid-frame aborts immediately with no eof.
- `out_*` are registered.
- Latency: payload byte i (0-based) is visible one cycle after the edge that samples byte i+5.
- The eof beat is visible after the edge that samples `in_rxdv`=0.
- `out_valid` may have gaps only at frame end. There is no back-pressure; the consumer must accept every beat.
- `out_dest_mac`, `out_src_mac` and `out_ether_type` are stable from `out_sof` until the next frame's SFD.
- Counters update on the same edge as the eof beat, or on the drop decision.
- Back-to-back frames need ≥1 idle cycle (`in_rxdv`=0).

## Configuration
- `MAC_RX_FCS_CHECK_EN` defined:
  - CRC-32 (reflected, poly 0xEDB88320, init 0xFFFFFFFF) runs over dest..FCS.
  - FCS is good iff the register equals 0xDEBB20E3 at end of frame.
- Undefined: no CRC logic; FCS is still stripped; `out_err` ignores FCS.

## Test plan
- 64-byte broadcast frame, 7×0x55 + 0xD5, correct FCS -> 46 payload beats with sof on the first and eof on the 46th, err=0, `out_frame_cnt`=1.
- Frame to 02:00:00:00:00:01 with station 02:00:00:00:00:02 and `in_promisc`=0 -> no `out_valid`, `out_drop_cnt`=1. Same frame with `in_promisc`=1 -> streamed.
- Corrupt one payload bit (FCS_CHECK_EN defined) -> eof beat with err=1, `out_drop_cnt`+1. Undefined -> err=0.
- `in_rxer` pulsed one cycle mid-payload -> err=1 on eof. 60-byte frame -> err=1 (runt). 1600-byte frame -> eof/err at byte 1519, then silence until `in_rxdv` drops.
- Preamble byte 0x5A -> DROP, no output. `in_rst_n` asserted mid-payload -> all outputs 0 immediately, next good frame parses normally.

Source files
------------

// File: rtl/mac_rx_parser.sv
// GMII receive MAC: preamble/SFD/header parse, destination filter, FCS stripped by a 4-byte delay line.
// Optional CRC-32 FCS check when MAC_RX_FCS_CHECK_EN is defined; all outputs registered, no back-pressure.
module mac_rx_parser #(
    parameter int MIN_FRAME = 64,
    parameter int MAX_FRAME = 1518,
    parameter int CNT_W     = 16
) (
    input  logic             in_rxc,
    input  logic             in_rst_n,
    input  logic             in_rxdv,
    input  logic [7:0]       in_rxd,
    input  logic             in_rxer,
    input  logic [47:0]      in_station_mac,
    input  logic             in_promisc,
    output logic             out_valid,
    output logic [7:0]       out_data,
    output logic             out_sof,
    output logic             out_eof,
    output logic             out_err,
    output logic [47:0]      out_dest_mac,
    output logic [47:0]      out_src_mac,
    output logic [15:0]      out_ether_type,
    output logic [CNT_W-1:0] out_frame_cnt,
    output logic [CNT_W-1:0] out_drop_cnt
);
    typedef enum logic [2:0] {S_IDLE, S_PREAMBLE, S_HEADER, S_PAYLOAD, S_DROP} state_t;

    localparam logic [10:0] MIN_L  = 11'(MIN_FRAME);
    localparam logic [10:0] OVER_L = 11'(MAX_FRAME + 1);

    state_t           state_q, state_d;
    logic [10:0]      cnt_q, cnt_d, cnt_inc;
    logic [47:0]      dest_q, dest_d, src_q, src_d, dest_nxt;
    logic [15:0]      type_q, type_d;
    logic [31:0]      dl_q, dl_d;
    logic [3:0]       dlv_q, dlv_d;
    logic [7:0]       p_q, p_d, data_q, data_d;
    logic             pv_q, pv_d, sof_done_q, sof_done_d, rxer_q, rxer_d;
    logic             vld_q, vld_d, sof_q, sof_d, eof_q, eof_d, err_q, err_d;
    logic [CNT_W-1:0] good_q, good_d, drop_q, drop_d;
    logic             good_inc, drop_inc, accept, fcs_bad, frm_err;

    assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 11'd1;
    assign dest_nxt = {dest_q[39:0], in_rxd};
    assign accept   = in_promisc || (dest_nxt == in_station_mac) || (dest_nxt == '1);
    assign frm_err  = rxer_q || in_rxer || (cnt_q < MIN_L) || fcs_bad;

`ifdef MAC_RX_FCS_CHECK_EN
    logic [31:0] crc_q;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // Runs over dest..FCS; a clean frame leaves the fixed CRC-32 residue.
    always_ff @(posedge in_rxc or negedge in_rst_n) begin
        if (!in_rst_n)
            crc_q <= '1;
        else if (state_q == S_PREAMBLE && in_rxdv && in_rxd == 8'hD5)
            crc_q <= '1;
        else if (in_rxdv && (state_q == S_HEADER || state_q == S_PAYLOAD))
            crc_q <= crc_byte(crc_q, in_rxd);
    end
    assign fcs_bad = (crc_q != 32'hDEBB20E3);
`else
    assign fcs_bad = 1'b0;
`endif

    always_comb begin
        state_d = state_q;  cnt_d = cnt_q;  dest_d = dest_q;  src_d = src_q;  type_d = type_q;
        dl_d = dl_q;  dlv_d = dlv_q;  p_d = p_q;  pv_d = pv_q;
        sof_done_d = sof_done_q;  rxer_d = rxer_q;  data_d = data_q;
        vld_d = 1'b0;  sof_d = 1'b0;  eof_d = 1'b0;  err_d = 1'b0;
        good_inc = 1'b0;  drop_inc = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_rxdv) begin
                    if (in_rxd == 8'h55) state_d = S_PREAMBLE;
                    else begin state_d = S_DROP; drop_inc = 1'b1; end
                end
            end
            S_PREAMBLE: begin
                if (!in_rxdv) begin
                    state_d = S_IDLE; drop_inc = 1'b1;
                end else if (in_rxd == 8'hD5) begin
                    state_d = S_HEADER;  cnt_d = '0;  rxer_d = 1'b0;  sof_done_d = 1'b0;
                    dl_d = '0;  dlv_d = '0;  p_d = '0;  pv_d = 1'b0;
                end else if (in_rxd != 8'h55) begin
                    state_d = S_DROP; drop_inc = 1'b1;
                end
            end
            S_HEADER: begin
                if (!in_rxdv) begin
                    state_d = S_IDLE; drop_inc = 1'b1;
                end else begin
                    cnt_d  = cnt_inc;
                    rxer_d = rxer_q | in_rxer;
                    if (cnt_q < 11'd6)       dest_d = dest_nxt;
                    else if (cnt_q < 11'd12) src_d  = {src_q[39:0], in_rxd};
                    else                     type_d = {type_q[7:0], in_rxd};
                    if (cnt_q == 11'd5 && !accept) begin
                        state_d = S_DROP; drop_inc = 1'b1;
                    end else if (cnt_q == 11'd13) begin
                        state_d = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (!in_rxdv) begin
                    state_d = S_IDLE;
                    if (pv_q) begin
                        vld_d = 1'b1;  data_d = p_q;  sof_d = !sof_done_q;  eof_d = 1'b1;  err_d = frm_err;
                        good_inc = !frm_err;  drop_inc = frm_err;
                    end else begin
                        drop_inc = 1'b1;
                    end
                end else begin
                    cnt_d  = cnt_inc;
                    rxer_d = rxer_q | in_rxer;
                    if (cnt_inc == OVER_L) begin
                        state_d = S_DROP;  drop_inc = 1'b1;
                        vld_d = pv_q;  data_d = p_q;  sof_d = pv_q && !sof_done_q;
                        eof_d = pv_q;  err_d = pv_q;
                    end else begin
                        dl_d  = {dl_q[23:0], in_rxd};
                        dlv_d = {dlv_q[2:0], 1'b1};
                        // Byte leaving the delay line is at least 4 bytes from the end, so it is payload.
                        if (dlv_q[3]) begin p_d = dl_q[31:24]; pv_d = 1'b1; end
                        if (pv_q) begin
                            vld_d = 1'b1;  data_d = p_q;  sof_d = !sof_done_q;  sof_done_d = 1'b1;
                        end
                    end
                end
            end
            S_DROP: begin
                if (!in_rxdv) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        good_d = (good_inc && good_q != '1) ? good_q + 1'b1 : good_q;
        drop_d = (drop_inc && drop_q != '1) ? drop_q + 1'b1 : drop_q;
    end

    always_ff @(posedge in_rxc or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q <= S_IDLE;  cnt_q <= '0;  dest_q <= '0;  src_q <= '0;  type_q <= '0;
            dl_q <= '0;  dlv_q <= '0;  p_q <= '0;  pv_q <= 1'b0;  sof_done_q <= 1'b0;  rxer_q <= 1'b0;
            vld_q <= 1'b0;  data_q <= '0;  sof_q <= 1'b0;  eof_q <= 1'b0;  err_q <= 1'b0;
            good_q <= '0;  drop_q <= '0;
        end else begin
            state_q <= state_d;  cnt_q <= cnt_d;  dest_q <= dest_d;  src_q <= src_d;  type_q <= type_d;
            dl_q <= dl_d;  dlv_q <= dlv_d;  p_q <= p_d;  pv_q <= pv_d;  sof_done_q <= sof_done_d;  rxer_q <= rxer_d;
            vld_q <= vld_d;  data_q <= data_d;  sof_q <= sof_d;  eof_q <= eof_d;  err_q <= err_d;
            good_q <= good_d;  drop_q <= drop_d;
        end
    end

    assign out_valid      = vld_q;
    assign out_data       = data_q;
    assign out_sof        = sof_q;
    assign out_eof        = eof_q;
    assign out_err        = err_q;
    assign out_dest_mac   = dest_q;
    assign out_src_mac    = src_q;
    assign out_ether_type = type_q;
    assign out_frame_cnt  = good_q;
    assign out_drop_cnt   = drop_q;
endmodule

// File: tb/tb_mac_rx_parser.sv
// Randomized bench for mac_rx_parser: frame-level reference model feeds an expected-beat queue,
// an independent monitor pops and compares every output beat.
`timescale 1ns/1ps
module tb_mac_rx_parser;
    localparam int MIN_FRAME = 64;
    localparam int MAX_FRAME = 1518;
    localparam int CNT_W     = 16;
`ifdef MAC_RX_FCS_CHECK_EN
    localparam bit FCS_EN = 1'b1;
`else
    localparam bit FCS_EN = 1'b0;
`endif
    localparam logic [47:0] BCAST = '1;

    logic clk = 1'b0, rst_n = 1'b0, rxdv = 1'b0, rxer = 1'b0, promisc = 1'b0;
    logic [7:0] rxd = 8'h00;
    logic [47:0] station = 48'h02_00_00_00_00_02;
    logic out_valid, out_sof, out_eof, out_err;
    logic [7:0] out_data;
    logic [47:0] out_dest_mac, out_src_mac;
    logic [15:0] out_ether_type;
    logic [CNT_W-1:0] out_frame_cnt, out_drop_cnt;

    mac_rx_parser #(.MIN_FRAME(MIN_FRAME), .MAX_FRAME(MAX_FRAME), .CNT_W(CNT_W)) dut (
        .in_rxc(clk), .in_rst_n(rst_n), .in_rxdv(rxdv), .in_rxd(rxd), .in_rxer(rxer),
        .in_station_mac(station), .in_promisc(promisc),
        .out_valid(out_valid), .out_data(out_data), .out_sof(out_sof), .out_eof(out_eof),
        .out_err(out_err), .out_dest_mac(out_dest_mac), .out_src_mac(out_src_mac),
        .out_ether_type(out_ether_type), .out_frame_cnt(out_frame_cnt), .out_drop_cnt(out_drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  d;
        bit          sof, eof, err;
        logic [47:0] dst, src;
        logic [15:0] typ;
    } beat_t;

    beat_t      exp_q[$];
    logic [7:0] fb[$];
    int total = 0, bad = 0, m_good = 0, m_drop = 0;
    bit ignore = 1'b0, in_fr = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int k = 0; k < 8; k++) r = (r[0] ^ b[k]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // Frame bytes after the SFD: header, random payload, then the correct FCS (LSB first).
    task automatic build(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] typ,
                         input int plen, input bit corrupt);
        logic [31:0] c;
        int j, k;
        fb.delete();
        for (int i = 0; i < 6; i++) fb.push_back(dst[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) fb.push_back(src[47-8*i -: 8]);
        fb.push_back(typ[15:8]);
        fb.push_back(typ[7:0]);
        for (int i = 0; i < plen; i++) fb.push_back(8'($urandom));
        c = '1;
        foreach (fb[i]) c = crc_next(c, fb[i]);
        c = ~c;
        for (int i = 0; i < 4; i++) fb.push_back(c[8*i +: 8]);
        if (corrupt && plen > 0) begin
            j = 14 + int'($urandom_range(0, plen - 1));
            k = int'($urandom_range(0, 7));
            fb[j] = fb[j] ^ (8'h01 << k);
        end
    endtask

    task automatic drive(input logic [7:0] b, input logic v, input logic e);
        @(negedge clk);
        rxdv = v; rxd = b; rxer = e;
    endtask

    task automatic send(input int pre_len, input int bad_idx, input int rxer_idx);
        for (int i = 0; i < pre_len; i++) drive((i == bad_idx) ? 8'h5A : 8'h55, 1'b1, 1'b0);
        drive(8'hD5, 1'b1, 1'b0);
        for (int i = 0; i < fb.size(); i++) drive(fb[i], 1'b1, i == rxer_idx);
        for (int i = 0; i < 4; i++) drive(8'h00, 1'b0, 1'b0);
    endtask

    // Model: a delivered frame yields every byte after the header except the last four (FCS),
    // capped at MAX_FRAME-18 beats when oversize; anything else is one drop.
    task automatic run_frame(input string name, input logic [47:0] dst, input int plen, input bit corrupt,
                             input int pre_len, input int bad_idx, input int rxer_idx, input int trunc);
        logic [47:0] src;
        logic [15:0] typ;
        int n, nb;
        bit acc, err;
        src = {16'h0A0B, 32'($urandom)};
        typ = 16'($urandom);
        build(dst, src, typ, plen, corrupt);
        if (trunc > 0) while (fb.size() > trunc) void'(fb.pop_back());
        n = fb.size();
        acc = (bad_idx < 0) && (promisc || dst == station || dst == BCAST);
        if (!acc || n < 19) begin
            m_drop++;
        end else begin
            if (n > MAX_FRAME) begin
                nb = MAX_FRAME - 18; err = 1'b1;
            end else begin
                nb = n - 18;
                err = (rxer_idx >= 0 && rxer_idx < n) || (n < MIN_FRAME) || (FCS_EN && corrupt);
            end
            for (int i = 0; i < nb; i++) begin
                beat_t b;
                b.d = fb[14+i]; b.sof = (i == 0); b.eof = (i == nb - 1); b.err = err;
                b.dst = dst; b.src = src; b.typ = typ;
                exp_q.push_back(b);
            end
            if (err) m_drop++; else m_good++;
        end
        send(pre_len, bad_idx, rxer_idx);
        repeat (2) @(negedge clk);
        check({name, "_good_cnt"}, 128'(out_frame_cnt), 128'(m_good));
        check({name, "_drop_cnt"}, 128'(out_drop_cnt), 128'(m_drop));
        check({name, "_beats_left"}, 128'(exp_q.size()), 128'(0));
    endtask

    always @(negedge clk) begin
        if (!rst_n || ignore) begin
            in_fr = 1'b0;
        end else if (out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 128'({out_data, out_sof, out_eof}), 128'(0));
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                check("beat", 128'({out_data, out_sof, out_eof}), 128'({e.d, e.sof, e.eof}));
                if (e.eof) check("eof_err", 128'(out_err), 128'(e.err));
                if (e.sof) check("sof_hdr", {out_dest_mac, out_src_mac, out_ether_type},
                                 {e.dst, e.src, e.typ});
            end
            in_fr = !out_eof;
        end else if (in_fr) begin
            check("beat_gap", 128'(out_valid), 128'(1));
            in_fr = 1'b0;
        end
    end

    initial begin
        logic [47:0] d;
        int plen, rx, bi, sel;
        bit cor;
        repeat (3) @(negedge clk);
        check("rst_beat", 128'({out_valid, out_sof, out_eof, out_err, out_data}), 128'(0));
        check("rst_cnt", 128'({out_frame_cnt, out_drop_cnt}), 128'(0));
        check("rst_hdr", {out_dest_mac, out_src_mac, out_ether_type}, 128'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_frame("bcast64",       BCAST,             46,   1'b0, 7, -1, -1,      0);
        run_frame("ucast_reject",  48'h020000000001,  46,   1'b0, 7, -1, -1,      0);
        promisc = 1'b1;
        run_frame("ucast_promisc", 48'h020000000001,  46,   1'b0, 7, -1, -1,      0);
        promisc = 1'b0;
        run_frame("station",       station,           50,   1'b0, 3, -1, -1,      0);
        run_frame("fcs_corrupt",   BCAST,             46,   1'b1, 7, -1, -1,      0);
        run_frame("rxer_pulse",    BCAST,             60,   1'b0, 7, -1, 14 + 20, 0);
        run_frame("runt60",        BCAST,             42,   1'b0, 7, -1, -1,      0);
        run_frame("oversize",      BCAST,             1582, 1'b0, 7, -1, -1,      0);
        run_frame("bad_preamble",  BCAST,             46,   1'b0, 7, 3,  -1,      0);
        run_frame("hdr_trunc",     BCAST,             46,   1'b0, 7, -1, -1,      10);
        run_frame("short17",       BCAST,             0,    1'b0, 7, -1, -1,      17);
        run_frame("min19",         BCAST,             10,   1'b0, 1, -1, -1,      19);

        for (int f = 0; f < 30; f++) begin
            plen = int'($urandom_range(0, 110));
            sel  = int'($urandom_range(0, 3));
            d = (sel == 0) ? station : (sel == 1) ? BCAST : {16'h0200, 32'($urandom)};
            promisc = ($urandom_range(0, 3) == 0);
            rx  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, plen + 17)) : -1;
            bi  = ($urandom_range(0, 9) == 0) ? 0 : -1;
            cor = (plen > 0) && ($urandom_range(0, 3) == 0);
            run_frame("rand", d, plen, cor, int'($urandom_range(1, 8)), bi, rx, 0);
        end
        promisc = 1'b0;

        // Reset in the middle of a payload: outputs clear at once, no eof, next frame parses normally.
        build(BCAST, 48'h0A0B0C0D0E0F, 16'h0800, 80, 1'b0);
        ignore = 1'b1;
        for (int i = 0; i < 7; i++) drive(8'h55, 1'b1, 1'b0);
        drive(8'hD5, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) drive(fb[i], 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_beat", 128'({out_valid, out_sof, out_eof, out_err, out_data}), 128'(0));
        check("midrst_cnt", 128'({out_frame_cnt, out_drop_cnt}), 128'(0));
        check("midrst_hdr", {out_dest_mac, out_src_mac, out_ether_type}, 128'(0));
        drive(8'h00, 1'b0, 1'b0);
        drive(8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;
        m_good = 0; m_drop = 0;
        exp_q.delete();
        ignore = 1'b0;
        drive(8'h00, 1'b0, 1'b0);
        run_frame("post_reset", BCAST, 46, 1'b0, 7, -1, -1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
